// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 streaming multiplexer with a registered single-stage output.
// Each cycle it grants one channel, chosen either by the sel input (mode=0) or
// round-robin across the requesting channels (mode=1).
// Optional feature: define STREAM_MUX_PARITY_EN to add the registered out_par port,
// which carries the XOR of all bits of out_data.
module stream_mux_rr #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic               out_par
`endif
);

  logic [WIDTH-1:0] chan_data [N];
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  cand;
  logic             found;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_chan_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  ptr_reg;
`ifdef STREAM_MUX_PARITY_EN
  logic             out_par_reg;
`endif

  // The output register can take a new word when it is empty or being drained.
  assign load = ~out_valid_reg | out_ready;

  // Split the flat input bus into per-channel words. Qualify each grant with load.
  // Also gate in_ready with rst, because while rst is high no word may be taken.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = grant[gi] & load & ~rst;
    end
  endgenerate

  // Arbitration: a fixed select with a range check, or a round-robin search.
  // The search starts at the channel after the last one granted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (!mode) begin
      if (32'(sel) < N) begin
        if (in_valid[sel]) begin
          grant[sel] = 1'b1;
          grant_idx  = sel;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = SELW'((int'(ptr_reg) + k) % N);
        if (!found && in_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign accept = (|grant) & load;
  assign word   = chan_data[grant_idx];

  // Output register and rr pointer. The register holds during a stall and clears
  // valid on a drain that has no new grant. On a drain with a new grant it is
  // replaced in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      ptr_reg       <= SELW'(N - 1);
`ifdef STREAM_MUX_PARITY_EN
      out_par_reg   <= 1'b0;
`endif
    end else if (load) begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= word;
        out_chan_reg  <= grant_idx;
`ifdef STREAM_MUX_PARITY_EN
        out_par_reg   <= ^word;
`endif
        if (mode) begin
          ptr_reg <= grant_idx;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;
`ifdef STREAM_MUX_PARITY_EN
  assign out_par   = out_par_reg;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr. The main instance is built with N=4. A second
// instance with N=5 covers the in-range and out-of-range cases of sel.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
`ifdef STREAM_MUX_PARITY_EN
  logic        out_par;
`endif

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic [2:0]  out_chan5;
  logic        out_valid5;
  logic        out_ready5;
`ifdef STREAM_MUX_PARITY_EN
  logic        out_par5;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [1:0] rr_chan  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [7:0] rr_data  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
  logic [3:0] rr_ready [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic [7:0] fx_data  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  stream_mux_rr #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef STREAM_MUX_PARITY_EN
    , .out_par(out_par)
`endif
  );

  stream_mux_rr #(.N(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .mode(mode5), .sel(sel5), .out_data(out_data5), .out_chan(out_chan5),
    .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef STREAM_MUX_PARITY_EN
    , .out_par(out_par5)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc %0d valid=%0b chan=%0d data=%02h ready=%04b | n5 valid=%0b chan=%0d data=%02h",
             cyc, out_valid, out_chan, out_data, in_ready, out_valid5, out_chan5, out_data5);
  endtask

  initial begin
    rst = 1'b1;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    in_data5 = '0; in_valid5 = '0; mode5 = 1'b0; sel5 = '0; out_ready5 = 1'b0;

    // Reset asserted in the middle of a cycle while the output holds a word.
    #12;
    rst = 1'b0;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_out_chan",  32'(out_chan),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'b0000);

    // Round-robin with all channels valid. The pointer comes out of reset at 3,
    // so channel 0 is granted first.
    #1;
    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_chan",  32'(out_chan),  32'(rr_chan[k]));
      chk("rr_data",  32'(out_data),  32'(rr_data[k]));
      chk("rr_ready", 32'(in_ready),  32'(rr_ready[k]));
    end

    // Sparse round-robin from ptr=1 with channels 1 and 3 valid: the grant order is 3, 1, 3.
    in_valid = 4'b1010;
    #1;
    chk("sparse_ready0", 32'(in_ready), 32'b1000);
    tick();
    chk("sparse_chan0", 32'(out_chan), 32'd3);
    chk("sparse_data0", 32'(out_data), 32'h44);
    chk("sparse_ready1", 32'(in_ready), 32'b0010);
    tick();
    chk("sparse_chan1", 32'(out_chan), 32'd1);
    chk("sparse_ready2", 32'(in_ready), 32'b1000);
    tick();
    chk("sparse_chan2", 32'(out_chan), 32'd3);

    // Fixed select, stepping sel 0..3 and then 1. None of these move the rr pointer.
    mode = 1'b0; in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("fix_ready", 32'(in_ready), 32'(4'b0001 << s));
      tick();
      chk("fix_chan", 32'(out_chan), 32'(s));
      chk("fix_data", 32'(out_data), 32'(fx_data[s]));
    end
    sel = 2'd1;
    tick();
    chk("fix_chan_s1", 32'(out_chan), 32'd1);
    mode = 1'b1;
    #1;
    chk("ptr_untouched_ready", 32'(in_ready), 32'b0001);

    // Backpressure: register A5, stall for 3 cycles, then drain and load in the same edge.
    mode = 1'b0; sel = 2'd0; in_data[7:0] = 8'hA5;
    tick();
    chk("bp_load_data", 32'(out_data), 32'hA5);
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(in_ready), 32'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data",  32'(out_data),  32'hA5);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_chan",  32'(out_chan),  32'd0);
      chk("bp_hold_ready", 32'(in_ready),  32'b0000);
    end
    out_ready = 1'b1; sel = 2'd2; in_valid = 4'b0100;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("bp_swap_valid", 32'(out_valid), 32'd1);
    chk("bp_swap_data",  32'(out_data),  32'h33);
    chk("bp_swap_chan",  32'(out_chan),  32'd2);

    // Drain with no grant: valid drops, data and channel keep their last values.
    in_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data",  32'(out_data),  32'h33);
    chk("drain_chan",  32'(out_chan),  32'd2);

    // N=5 build: sel=4 is in range; sel=6 is out of range, so there is no grant.
    mode5 = 1'b0; sel5 = 3'd4; in_valid5 = 5'b10000; in_data5[39:32] = 8'h5A; out_ready5 = 1'b1;
    #1;
    chk("n5_ready_sel4", 32'(in_ready5), 32'b10000);
    tick();
    chk("n5_chan_sel4",  32'(out_chan5),  32'd4);
    chk("n5_data_sel4",  32'(out_data5),  32'h5A);
    chk("n5_valid_sel4", 32'(out_valid5), 32'd1);
    sel5 = 3'd6; in_valid5 = 5'b11111;
    #1;
    chk("n5_ready_sel6", 32'(in_ready5), 32'b00000);
    tick();
    chk("n5_valid_sel6", 32'(out_valid5), 32'd0);
    chk("n5_chan_sel6",  32'(out_chan5),  32'd4);

`ifdef STREAM_MUX_PARITY_EN
    // Parity: 07 has three 1s, so out_par=1. 03 has two 1s, so out_par=0.
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[7:0] = 8'h07;
    tick();
    chk("par_07", 32'(out_par), 32'd1);
    in_data[7:0] = 8'h03;
    tick();
    chk("par_03", 32'(out_par), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
